// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: shared format constants, stage payload and bit-placement
// helper for the RV32 immediate encoder. The immediate extender decodes the
// same ImmSrc values, so both sides agree on format numbering.
package imm_encoder_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_U = 2'b11;

  // One operation as it travels through stage 1.
  typedef struct packed {
    logic [1:0]  ImmSrc;
    logic [31:0] imm;
    logic [31:0] base;
    logic        err;
  } imm_stage_t;

  // Scatter imm into the format's immediate fields; every other bit comes
  // from base. Out-of-range immediates are simply truncated here.
  function automatic logic [31:0] imm_place(input logic [1:0]  src,
                                            input logic [31:0] imm,
                                            input logic [31:0] base);
    logic [31:0] r;
    r = base;
    case (src)
      IMM_I: r[31:20] = imm[11:0];
      IMM_S: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      IMM_B: begin
        r[31]    = imm[12];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
        r[7]     = imm[11];
      end
      default: r[31:12] = imm[31:12];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/result handshake bundle for imm_encoder.
// master = producer of requests / consumer of results, slave = the encoder.
interface imm_encoder_if #(
  parameter int ERR_CNT_W = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           ImmSrc;
  logic [31:0]          imm;
  logic [31:0]          base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          instr;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, ImmSrc, imm, base, out_ready,
    input  in_ready, out_valid, instr, err, err_count
  );

  modport slave (
    input  in_valid, ImmSrc, imm, base, out_ready,
    output in_ready, out_valid, instr, err, err_count
  );
endinterface

// File: rtl/imm_encoder_range_check.sv
// imm_range_check: combinational representability test of an immediate in
// the selected RV32 format. Only instantiated when IMM_RANGE_CHECK_EN is set.
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [1:0]  i_imm_src,
  input  logic [31:0] i_imm,
  output logic        o_err
);

  logic w_hi11_same;  // imm[31:11] is a pure sign extension (12-bit range)
  logic w_hi12_same;  // imm[31:12] is a pure sign extension (13-bit range)

  assign w_hi11_same = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_hi12_same = (&i_imm[31:12]) | ~(|i_imm[31:12]);

  // Flag any immediate the extender could not reproduce from this format.
  always_comb begin
    o_err = 1'b0;
    case (i_imm_src)
      IMM_I, IMM_S: o_err = ~w_hi11_same;
      IMM_B:        o_err = ~w_hi12_same | i_imm[0];
      default:      o_err = |i_imm[11:0];
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready RV32 immediate encoder.
// Stage 1 holds the raw request and evaluates the range check, stage 2 holds
// the assembled instruction. Optional feature macro: IMM_RANGE_CHECK_EN
// (range check, err and err_count live only when defined).
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_encoder_if.slave  bus
);

  imm_stage_t  r_s1;
  logic        r_s1_vld;
  logic        r_s2_vld;
  logic [31:0] r_instr;
  logic        r_err;

  imm_stage_t  w_s1;
  logic        w_chk_err;
  logic        w_s1_adv;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_out_hs;

  // Each stage refills when empty or when its consumer is taking data.
  assign w_s1_adv   = ~r_s2_vld | bus.out_ready;
  assign w_in_ready = ~r_s1_vld | w_s1_adv;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_out_hs   = r_s2_vld & bus.out_ready;

`ifdef IMM_RANGE_CHECK_EN
  imm_range_check u_chk (
    .i_imm_src (r_s1.ImmSrc),
    .i_imm     (r_s1.imm),
    .o_err     (w_chk_err)
  );
`else
  assign w_chk_err = 1'b0;
`endif

  // Stage-1 payload with the range verdict folded in.
  always_comb begin
    w_s1     = r_s1;
    w_s1.err = w_chk_err;
  end

  // Stage 1: capture the request on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
    end else if (w_in_ready) begin
      r_s1_vld <= bus.in_valid;
      if (w_accept) begin
        r_s1.ImmSrc <= bus.ImmSrc;
        r_s1.imm    <= bus.imm;
        r_s1.base   <= bus.base;
        r_s1.err    <= 1'b0;
      end
    end
  end

  // Stage 2: assemble the instruction; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_instr  <= '0;
      r_err    <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_instr <= imm_place(w_s1.ImmSrc, w_s1.imm, w_s1.base);
        r_err   <= w_s1.err;
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Count errored results at hand-off, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (w_out_hs && r_err && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign bus.err_count = r_err_cnt;
`else
  assign bus.err_count = '0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_vld;
  assign bus.instr     = r_instr;
  assign bus.err       = r_err;

endmodule

// File: doc/imm_encoder.md
# imm_encoder

- Pipelined RV32 immediate encoder: packs a 32-bit immediate into the I/S/B/U bit positions of a base instruction word.
- Inverse of the core's immediate extender: for every accepted operation with `err`=0, extending the output with the same `ImmSrc` reproduces `imm` exactly.
- Sits in the boot/self-test path, where the loader and test generator synthesise branch, store and load-upper words at run time.
- Two-stage valid/ready pipeline with full throughput and backpressure.

## Interface
- `ERR_CNT_W`, default 8: width of the saturating error counter.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid` and `in_ready` are both high.
- `ImmSrc` input 2: format select, same encoding as the extender: 00=I, 01=S, 10=B, 11=U.
- `imm` input 32: immediate value, two's complement.
- `base` input 32: instruction word carrying opcode/rd/rs/funct fields; its immediate bit positions are ignored.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid` and `out_ready` are both high.
- `instr` output 32: encoded instruction.
- `err` output 1: `imm` is not representable in the selected format.
- `err_count` output `ERR_CNT_W`: count of errored results handed off, saturating.

## Operation
- Bit placement. All non-listed bits of `instr` are copied from `base`.
  - I: `instr[31:20]` = `imm[11:0]`.
  - S: `instr[31:25]` = `imm[11:5]`; `instr[11:7]` = `imm[4:0]`.
  - B: `instr[31]` = `imm[12]`; `instr[7]` = `imm[11]`; `instr[30:25]` = `imm[10:5]`; `instr[11:8]` = `imm[4:1]`.
  - U: `instr[31:12]` = `imm[31:12]`.
- Range rules:
  - I and S: `imm[31:11]` all equal.
  - B: `imm[31:12]` all equal and `imm[0]`=0.
  - U: `imm[11:0]`=0.
  - A violation sets `err`; `instr` still carries the truncated bits. No saturation or rounding.
- Stage 1 registers `ImmSrc`/`imm`/`base` and computes the range check.
- Stage 2 registers the assembled `instr` and `err`.
- Each stage loads when it is empty or its downstream consumer is ready: `in_ready` = !s1_valid | s1_advance; s1_advance = !s2_valid | `out_ready`.
- Pipeline holds at most 2 operations. No drop, no duplication, order preserved.
- `err_count` increments on each output handshake with `err`=1, and holds at all-ones.

## Timing
- Latency: an operation accepted in cycle N appears on `out_valid` in cycle N+2 when there is no backpressure.
- Throughput: 1 per cycle.
- Outputs are fully registered. `in_ready` is combinational from `out_ready` and internal valids.
- Reset values: `out_valid`=0, `instr`=0, `err`=0, `err_count`=0. `in_ready` reads 1 once reset is released.
- Reset asserted mid-operation clears both stages immediately; in-flight operations are lost.
- Simultaneous accept and output handshake in the same cycle is legal and is the steady-state case.
- While `out_valid`=1 and `out_ready`=0, `instr` and `err` hold stable.

## Configuration
- `IMM_RANGE_CHECK_EN` defined: range rules evaluated; `err` and `err_count` behave as above.
- `IMM_RANGE_CHECK_EN` undefined: range logic removed; `err` is tied to 0 and `err_count` stays 0. Ports remain. Bit placement and timing are unchanged.

## Structure
- Shared package holds:
  - format constants `IMM_I`=2'b00, `IMM_S`=2'b01, `IMM_B`=2'b10, `IMM_U`=2'b11;
  - a stage payload struct (`ImmSrc`, `imm`, `base`, `err`).
- The extender uses the same format constants.
- One sub-module: `imm_range_check`, combinational: (`ImmSrc`, `imm`) -> `err`. It is instantiated only under the macro.

## Test plan
- I: `base`=0x00000013, `imm`=0xFFFFFFFF -> `instr`=0xFFF00013, `err`=0, output 2 cycles after accept.
- S and U:
  - `base`=0x00002023, `imm`=0x00000004 -> `instr`=0x00002223.
  - `base`=0x00000037, `imm`=0x12345000 -> `instr`=0x12345037.
- B: `base`=0x00000063, `imm`=0xFFFFFFFC -> `instr`=0xFE000EE3. Extender round-trip returns 0xFFFFFFFC.
- Errors (macro on):
  - I, `imm`=0x00000800 -> `err`=1, `instr`=0x80000013, `err_count`=1.
  - B, `imm`=0x00000003 -> `err`=1, `err_count`=2.
  - 300 errored results -> `err_count` holds at 255.
- Backpressure: hold `out_ready`=0 and offer 3 ops -> 2 accepted, `in_ready`=0. Release -> 3 outputs in order on consecutive cycles.
- Reset: assert `rst_n`=0 with 2 ops in flight -> `out_valid`=0 and `err_count`=0 immediately; no stale output after release.
